clock_set_ctrl: RTL and testbench

Mode and enable sequencer for the 24-hour clock's second, minute and hour counter chain. In RUN mode it passes the 1 Hz tick and the counter carries through as counter enables. In SET modes it freezes the chain, steps the hour or minute counter from the SET button, and generates blink indications for the display. It sits between the 1 Hz prescaler, the debounced buttons and the three BCD counters.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/clock_set_ctrl_btn_edge.sv | 37 +++
 rtl/clock_set_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the 24-hour clock mode/enable sequencer.
//   mode_e     : operating mode as presented on MODE (RUN / SET_H / SET_M)
//   MODE_W     : width of the mode field
//   cnt_width  : bits needed for a counter that must hold 0..n-1 (min 1)
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN   = 2'b00,
    MODE_SET_H = 2'b01,
    MODE_SET_M = 2'b10,
    MODE_BAD   = 2'b11   // unreachable; recovers to RUN on the next cycle
  } mode_e;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Registers a debounced, synchronised button level once and produces a
// one-cycle press pulse on its rising edge. The pulse appears in the cycle
// after the input is first seen high.
// Ports:
//   CLK   : system clock
//   RST   : asynchronous reset, active-low
//   btn   : debounced button level
//   press : one-cycle rising-edge pulse
// ---------------------------------------------------------------------------
module btn_edge
  import clock_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  logic lvl_r;
  logic prev_r;

  // Capture the button level and keep a one-cycle-old copy for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lvl_r  <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      lvl_r  <= btn;
      prev_r <= lvl_r;
    end
  end

  assign press = lvl_r & ~prev_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Mode and enable sequencer for the seconds/minutes/hours BCD counter chain.
// RUN passes the 1 Hz tick and counter carries through as enables; SET_H and
// SET_M freeze the chain, step the selected field from SET presses and blink
// that field on the display.
//
// Optional build macro: CLOCK_SET_AUTOREPEAT_EN
//   defined   : holding SET in a SET mode produces auto-repeat steps after
//               REPEAT_DLY cycles, then every REPEAT_RATE cycles
//   undefined : exactly one step per SET rising edge, no repeat timer
//
// Ports:
//   CLK      : system clock
//   RST      : asynchronous reset, active-low
//   SEC_TICK : 1 Hz one-cycle tick from the prescaler
//   MODE_BTN : debounced MODE level, rising edge advances the mode
//   SET_BTN  : debounced SET level, rising edge steps the selected field
//   SEC_CA   : seconds counter carry
//   MIN_CA   : minutes counter carry
//   SEC_EN   : seconds counter enable
//   MIN_EN   : minutes counter enable
//   HOUR_EN  : hours counter enable
//   SEC_CLR  : one-cycle clear to the seconds counter on leaving SET_M
//   MODE     : current mode (00 RUN, 01 SET_H, 10 SET_M)
//   BLINK_H  : hour digits blank phase
//   BLINK_M  : minute digits blank phase
// ---------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_DIV   = 25000000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEC_TICK,
  input  logic              MODE_BTN,
  input  logic              SET_BTN,
  input  logic              SEC_CA,
  input  logic              MIN_CA,
  output logic              SEC_EN,
  output logic              MIN_EN,
  output logic              HOUR_EN,
  output logic              SEC_CLR,
  output logic [MODE_W-1:0] MODE,
  output logic              BLINK_H,
  output logic              BLINK_M
);

  localparam int                   BLINK_W    = cnt_width(BLINK_DIV);
  localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  mode_e              state_r;
  mode_e              state_nxt_s;
  logic               mode_press_s;
  logic               set_edge_s;
  logic               rpt_pulse_s;
  logic               set_pulse_s;
  logic               in_set_s;
  logic               eff_set_s;
  logic               sec_clr_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_ph_r;

  btn_edge u_mode_edge (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (MODE_BTN),
    .press (mode_press_s)
  );

  btn_edge u_set_edge (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (SET_BTN),
    .press (set_edge_s)
  );

  assign in_set_s    = (state_r == MODE_SET_H) | (state_r == MODE_SET_M);
  assign set_pulse_s = set_edge_s | rpt_pulse_s;
  // A MODE press in the same cycle wins; SET steps only count in a SET mode.
  assign eff_set_s   = set_pulse_s & in_set_s & ~mode_press_s;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int                 RPT_W      = cnt_width(REPEAT_DLY + 1);
  localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(REPEAT_DLY);
  // After each repeat the timer restarts so it reaches RPT_LAST again
  // REPEAT_RATE cycles later (REPEAT_RATE is expected to be <= REPEAT_DLY+1).
  localparam int                 RPT_RLD_I  = (REPEAT_RATE > REPEAT_DLY) ? 0
                                              : (REPEAT_DLY - REPEAT_RATE + 1);
  localparam logic [RPT_W-1:0]   RPT_RELOAD = RPT_W'(RPT_RLD_I);

  logic [RPT_W-1:0] rpt_cnt_r;

  // Hold timer: counts cycles SET has been held in a SET mode
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rpt_cnt_r <= '0;
    end else if (!SET_BTN || !in_set_s || mode_press_s) begin
      rpt_cnt_r <= '0;
    end else if (rpt_cnt_r == RPT_LAST) begin
      rpt_cnt_r <= RPT_RELOAD;
    end else begin
      rpt_cnt_r <= rpt_cnt_r + 1'b1;
    end
  end

  assign rpt_pulse_s = SET_BTN & in_set_s & (rpt_cnt_r == RPT_LAST);
`else
  assign rpt_pulse_s = 1'b0;
`endif

  // Mode state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= MODE_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-mode decode: each MODE press advances RUN -> SET_H -> SET_M -> RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MODE_RUN: begin
        if (mode_press_s) begin
          state_nxt_s = MODE_SET_H;
        end else begin
          state_nxt_s = MODE_RUN;
        end
      end
      MODE_SET_H: begin
        if (mode_press_s) begin
          state_nxt_s = MODE_SET_M;
        end else begin
          state_nxt_s = MODE_SET_H;
        end
      end
      MODE_SET_M: begin
        if (mode_press_s) begin
          state_nxt_s = MODE_RUN;
        end else begin
          state_nxt_s = MODE_SET_M;
        end
      end
      default: begin
        state_nxt_s = MODE_RUN;
      end
    endcase
  end

  // Counter enables, decoded from the registered mode with zero input latency
  always_comb begin
    SEC_EN  = 1'b0;
    MIN_EN  = 1'b0;
    HOUR_EN = 1'b0;
    case (state_r)
      MODE_RUN: begin
        SEC_EN  = SEC_TICK;
        MIN_EN  = SEC_CA;
        HOUR_EN = MIN_CA;
      end
      MODE_SET_H: begin
        HOUR_EN = eff_set_s;
      end
      MODE_SET_M: begin
        // MIN_CA deliberately ignored: a minute wrap must not bump the hour.
        MIN_EN = eff_set_s;
      end
      default: begin
        SEC_EN  = 1'b0;
        MIN_EN  = 1'b0;
        HOUR_EN = 1'b0;
      end
    endcase
  end

  // Seconds clear: one cycle, in the first RUN cycle after leaving SET_M
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sec_clr_r <= 1'b0;
    end else begin
      sec_clr_r <= (state_r == MODE_SET_M) & (state_nxt_s == MODE_RUN);
    end
  end

  // Blink timebase: restarts on any mode change or step so the field is visible
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if ((state_nxt_s != state_r) || eff_set_s) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= ~blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  assign SEC_CLR = sec_clr_r;
  assign MODE    = state_r;
  assign BLINK_H = blink_ph_r & (state_r == MODE_SET_H);
  assign BLINK_M = blink_ph_r & (state_r == MODE_SET_M);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed-plus-random bench for clock_set_ctrl. A behavioural model tracks
// the mode as a number 0..2, button history as sampled levels, blink as
// "cycles since last restart" and auto-repeat as "cycles SET held".
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int BDIV  = 4;
  localparam int RDLY  = 8;
  localparam int RRATE = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SEC_TICK = 1'b0;
  logic       MODE_BTN = 1'b0;
  logic       SET_BTN = 1'b0;
  logic       SEC_CA = 1'b0;
  logic       MIN_CA = 1'b0;
  logic       SEC_EN;
  logic       MIN_EN;
  logic       HOUR_EN;
  logic       SEC_CLR;
  logic [1:0] MODE;
  logic       BLINK_H;
  logic       BLINK_M;

  clock_set_ctrl #(
    .BLINK_DIV   (BDIV),
    .REPEAT_DLY  (RDLY),
    .REPEAT_RATE (RRATE)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SEC_TICK (SEC_TICK),
    .MODE_BTN (MODE_BTN),
    .SET_BTN  (SET_BTN),
    .SEC_CA   (SEC_CA),
    .MIN_CA   (MIN_CA),
    .SEC_EN   (SEC_EN),
    .MIN_EN   (MIN_EN),
    .HOUR_EN  (HOUR_EN),
    .SEC_CLR  (SEC_CLR),
    .MODE     (MODE),
    .BLINK_H  (BLINK_H),
    .BLINK_M  (BLINK_M)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_mode;        // 0 RUN, 1 SET_H, 2 SET_M
  int m_prev_mode;   // mode in the previous cycle
  bit mp1, mp2;      // MODE_BTN one and two cycles ago
  bit sp1, sp2;      // SET_BTN one and two cycles ago
  int m_since;       // cycles since the blink timebase last restarted
  int m_held;        // cycles SET has been held in a SET mode
  int n_min_obs;
  int n_hour_obs;
  int exp_hold;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev_mode = 0;
    mp1 = 1'b0; mp2 = 1'b0; sp1 = 1'b0; sp2 = 1'b0;
    m_since = 0; m_held = 0;
  endtask

  function automatic bit rpt_due();
`ifdef CLOCK_SET_AUTOREPEAT_EN
    return (m_mode != 0) && SET_BTN && (m_held >= RDLY) && (((m_held - RDLY) % RRATE) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] outs();
    return {SEC_EN, MIN_EN, HOUR_EN, SEC_CLR, MODE, BLINK_H, BLINK_M};
  endfunction

  // one clock cycle: predict, sample at negedge, advance model at posedge
  task automatic step(input string tag);
    bit mpress, spress, eff, phase, clr;
    logic [2:0] en;
    logic [7:0] exp;
    int nxt;
    mpress = mp1 && !mp2;
    spress = (sp1 && !sp2) || rpt_due();
    eff    = spress && (m_mode != 0) && !mpress;
    case (m_mode)
      0:       en = {SEC_TICK, SEC_CA, MIN_CA};
      1:       en = {1'b0, 1'b0, eff};
      default: en = {1'b0, eff, 1'b0};
    endcase
    clr   = (m_mode == 0) && (m_prev_mode == 2);
    phase = ((m_since / BDIV) % 2) == 1;
    exp   = {en, clr, 2'(m_mode), phase && (m_mode == 1), phase && (m_mode == 2)};
    @(negedge CLK);
    check(tag, outs(), exp);
    if (MIN_EN === 1'b1) n_min_obs++;
    if (HOUR_EN === 1'b1) n_hour_obs++;
    @(posedge CLK);
    nxt = mpress ? ((m_mode + 1) % 3) : m_mode;
    m_since = ((nxt != m_mode) || eff) ? 0 : m_since + 1;
    m_held  = (SET_BTN && (m_mode != 0) && !mpress) ? m_held + 1 : 0;
    m_prev_mode = m_mode;
    m_mode = nxt;
    mp2 = mp1; mp1 = MODE_BTN;
    sp2 = sp1; sp1 = SET_BTN;
    #1;
  endtask

  task automatic run(input int n, input string tag, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        SEC_TICK = ($urandom_range(2, 0) == 0);
        SEC_CA   = ($urandom_range(3, 0) == 0);
        MIN_CA   = ($urandom_range(3, 0) == 0);
      end
      step(tag);
    end
  endtask

  task automatic mode_press(input string tag);
    MODE_BTN = 1'b1; run(2, tag, 1'b1);
    MODE_BTN = 1'b0; run(3, tag, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    model_reset();
    n_min_obs = 0; n_hour_obs = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", outs(), 8'h00);
    RST = 1'b1;

    // RUN pass-through
    run(12, "run_rand", 1'b1);
    SEC_TICK = 1'b1; SEC_CA = 1'b1; MIN_CA = 1'b0; step("run_sec_min");
    SEC_TICK = 1'b0; SEC_CA = 1'b0; MIN_CA = 1'b1; step("run_hour");
    MIN_CA = 1'b0;
    SET_BTN = 1'b1; run(2, "run_set_ignored", 1'b0);
    SET_BTN = 1'b0; run(2, "run_set_ignored", 1'b0);

    // full mode cycle, including SEC_CLR on return to RUN
    for (int k = 0; k < 3; k++) mode_press("mode_cycle");

    // SET_H: three steps, chain frozen
    mode_press("to_set_h");
    SEC_TICK = 1'b1; SEC_CA = 1'b1; MIN_CA = 1'b1;
    n_hour_obs = 0;
    for (int k = 0; k < 3; k++) begin
      SET_BTN = 1'b1; run(2, "seth_set", 1'b0);
      SET_BTN = 1'b0; run(4, "seth_set", 1'b0);
    end
    check("seth_pulse_count", 8'(n_hour_obs), 8'd3);

    // blink in SET_H, restarted by a step
    SEC_TICK = 1'b0; SEC_CA = 1'b0; MIN_CA = 1'b0;
    run(13, "seth_blink", 1'b0);
    SET_BTN = 1'b1; run(2, "seth_blink_set", 1'b0);
    SET_BTN = 1'b0; run(10, "seth_blink", 1'b0);

    // SET_M: minute step, carry ignored
    mode_press("to_set_m");
    n_min_obs = 0; n_hour_obs = 0;
    MIN_CA = 1'b1;
    SET_BTN = 1'b1; run(2, "setm_set", 1'b0);
    SET_BTN = 1'b0; run(3, "setm_set", 1'b0);
    check("setm_min_count", 8'(n_min_obs), 8'd1);
    check("setm_hour_count", 8'(n_hour_obs), 8'd0);
    MIN_CA = 1'b0;

    // MODE and SET together: mode wins, no step
    n_min_obs = 0;
    MODE_BTN = 1'b1; SET_BTN = 1'b1; run(2, "mode_set_same", 1'b0);
    MODE_BTN = 1'b0; SET_BTN = 1'b0; run(3, "mode_set_same", 1'b0);
    check("mode_set_same_min", 8'(n_min_obs), 8'd0);

    // back to SET_M and hold SET for 20 cycles
    mode_press("to_set_m2");
    mode_press("to_set_m2");
    n_min_obs = 0;
    SET_BTN = 1'b1; run(20, "setm_hold", 1'b0);
    SET_BTN = 1'b0; run(3, "setm_hold", 1'b0);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_hold = 5;
`else
    exp_hold = 1;
`endif
    check("setm_hold_count", 8'(n_min_obs), 8'(exp_hold));

    // random soak
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5, 0) == 0) MODE_BTN = ~MODE_BTN;
      if ($urandom_range(3, 0) == 0) SET_BTN = ~SET_BTN;
      run(1, "random", 1'b1);
    end

    // asynchronous reset in the middle of SET_M
    MODE_BTN = 1'b0; SET_BTN = 1'b0;
    run(3, "settle", 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (m_mode != 2) mode_press("nav_set_m");
    end
    run(6, "pre_rst", 1'b0);
    SEC_TICK = 1'b0; SEC_CA = 1'b0; MIN_CA = 1'b0;
    #2 RST = 1'b0;
    #1 check("async_rst", outs(), 8'h00);
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b1;
    run(10, "post_rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
